// File: rtl/round_robin_arbiter16.sv
// rtl/round_robin_arbiter16.sv - 16-way round-robin arbiter with grant hold limit and timeout pulse
`timescale 1ns/1ps

module round_robin_arbiter16 #(
    parameter int unsigned HOLD_MAX = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] req,
    input  logic        done,
    output logic        gnt_valid,
    output logic [3:0]  gnt_idx,
    output logic [15:0] gnt,
    output logic        timeout,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);
    localparam logic       HOLD_EN  = (HOLD_MAX != 0);

    state_t     state;
    logic [3:0] ptr;
    logic [7:0] hold_cnt;

    logic       win_found;
    logic [3:0] win_idx;
    logic       holder_req;
    logic       limit_hit;
    logic       grant_exit;

    // Round-robin search: first set request at or above ptr, wrapping 15 -> 0.
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr;
        for (int k = 0; k < 16; k++) begin
            logic [3:0] cand;
            cand = ptr + 4'(k);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Exit conditions for the current grant; the limit alone is what counts as a timeout.
    always_comb begin
        holder_req = req[gnt_idx];
        limit_hit  = HOLD_EN && (hold_cnt == HOLD_LIM);
        grant_exit = done || !holder_req || limit_hit;
    end

    // Arbiter FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= 4'd0;
            hold_cnt  <= 8'd0;
            gnt_valid <= 1'b0;
            gnt_idx   <= 4'd0;
            gnt       <= 16'h0000;
            timeout   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        state     <= GRANT;
                        hold_cnt  <= 8'd1;
                        gnt_valid <= 1'b1;
                        gnt_idx   <= win_idx;
                        gnt       <= 16'h0001 << win_idx;
                        timeout   <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                GRANT: begin
                    if (grant_exit) begin
                        state     <= RELEASE;
                        ptr       <= gnt_idx + 4'd1;
                        hold_cnt  <= 8'd0;
                        gnt_valid <= 1'b0;
                        gnt       <= 16'h0000;
                        // done or a dropped request takes precedence over the limit
                        timeout   <= limit_hit && !done && holder_req;
                    end else begin
                        hold_cnt  <= hold_cnt + 8'd1;
                    end
                end
                RELEASE: begin
                    state   <= IDLE;
                    timeout <= 1'b0;
                    busy    <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    hold_cnt  <= 8'd0;
                    gnt_valid <= 1'b0;
                    gnt       <= 16'h0000;
                    timeout   <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
